snake_dir_input: RTL

Button-conditioning stage that sits directly upstream of the snake game core. It synchronizes and debounces the four raw direction buttons, rejects reversals and repeats, and buffers up to two pending turns. It releases one turn per move tick, so the core sees a clean, registered `moveway` that changes only on move steps. It replaces the core's direct, unfiltered sampling of `direction`.

---
 rtl/snake_dir_input.sv | 116 +++++++++++
 1 files changed

// File: rtl/snake_dir_input.sv
// Direction-button conditioning for the snake core: 2-flop sync, per-bit debounce,
// press detection, reversal/repeat filter and a 2-deep turn queue released on move ticks.
module snake_dir_input #(
  parameter int unsigned DEB_CYCLES = 20000,
  parameter int unsigned DEB_W      = 15
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic [3:0] direction,
  input  logic       tick_mv,
  output logic [1:0] moveway,
  output logic       dir_changed,
  output logic [1:0] q_count,
  output logic       overrun
);

  localparam logic [DEB_W-1:0] CNT_MAX = DEB_W'(DEB_CYCLES - 1);

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_deb;
  logic [3:0]       r_press;
  logic [DEB_W-1:0] r_cnt [4];

  logic [1:0] r_moveway;
  logic [1:0] r_q0;
  logic [1:0] r_q1;
  logic [1:0] r_qcnt;
  logic       r_overrun;
  logic       r_pop_d;
  logic       r_dir_changed;

  logic       w_pop;
  logic       w_push;
  logic       w_any;
  logic [1:0] w_cnt_pp;
  logic [1:0] w_ref;
  logic [1:0] w_code;
  logic [3:0] w_valid;

  // r_press is the one-cycle rising edge of r_deb, registered alongside the flip
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_press <= '0;
      for (int unsigned k = 0; k < 4; k++) r_cnt[k] <= '0;
    end else begin
      r_sync1 <= direction;
      r_sync2 <= r_sync1;
      r_press <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        if (r_sync2[k] == r_deb[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CNT_MAX) begin
          r_deb[k]   <= ~r_deb[k];
          r_press[k] <= ~r_deb[k];
          r_cnt[k]   <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Reference is the post-pop queue tail, else the heading moveway will hold next
  always_comb begin
    w_pop    = tick_mv && (r_qcnt != 2'd0);
    w_cnt_pp = r_qcnt - {1'b0, w_pop};
    if (w_cnt_pp == 2'd2)      w_ref = r_q1;
    else if (w_cnt_pp == 2'd1) w_ref = w_pop ? r_q1 : r_q0;
    else                       w_ref = w_pop ? r_q0 : r_moveway;
    for (int unsigned k = 0; k < 4; k++) begin
      w_valid[k] = r_press[k] && (2'(k) != w_ref) && ((2'(k) ^ w_ref) != 2'b11);
    end
    w_any  = |w_valid;
    w_code = 2'd0;
    if (w_valid[3])      w_code = 2'd3;
    else if (w_valid[0]) w_code = 2'd0;
    else if (w_valid[1]) w_code = 2'd1;
    else if (w_valid[2]) w_code = 2'd2;
    w_push = w_any && (w_cnt_pp != 2'd2);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_moveway     <= 2'b11;
      r_q0          <= '0;
      r_q1          <= '0;
      r_qcnt        <= '0;
      r_overrun     <= 1'b0;
      r_pop_d       <= 1'b0;
      r_dir_changed <= 1'b0;
    end else begin
      if (w_pop) begin
        r_moveway <= r_q0;
        r_q0      <= r_q1;
      end
      if (w_push) begin
        if (w_cnt_pp == 2'd0) r_q0 <= w_code;
        else                  r_q1 <= w_code;
      end
      r_qcnt <= w_cnt_pp + {1'b0, w_push};
      if (w_any && !w_push) r_overrun <= 1'b1;
      r_pop_d       <= w_pop;
      r_dir_changed <= r_pop_d;
    end
  end

  assign moveway     = r_moveway;
  assign dir_changed = r_dir_changed;
  assign q_count     = r_qcnt;
  assign overrun     = r_overrun;

endmodule
